// File: rtl/ysyx_24110006_stage_ctrl.sv
// Multi-cycle sequencer for the IFU -> IDU -> EXU -> LSU -> WB stage chain.
// Define YSYX_STAGE_CTRL_PERF_EN to build the cycle/retire performance counters.
module ysyx_24110006_stage_ctrl #(
    parameter int RESET_STALL = 2,
    parameter int LSU_TIMEOUT = 255
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    output logic        o_ifu_req,
    input  logic        i_ifu_done,
    output logic        o_idu_req,
    input  logic        i_idu_done,
    input  logic [6:0]  i_op,
    input  logic [2:0]  i_csr_t,
    input  logic        i_halt_req,
    output logic        o_exu_req,
    input  logic        i_exu_done,
    output logic        o_lsu_req,
    input  logic        i_lsu_done,
    input  logic        i_lsu_err,
    output logic        o_pc_we,
    output logic        o_rf_we,
    output logic        o_csr_we,
    output logic        o_trap,
    output logic        o_halted,
    output logic [2:0]  o_state,
    output logic [31:0] o_perf_cycle,
    output logic [31:0] o_perf_instret
);

    typedef enum logic [2:0] {
        RST_WAIT = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        EXEC     = 3'd3,
        MEM      = 3'd4,
        WB       = 3'd5,
        TRAP     = 3'd6,
        HALT     = 3'd7
    } state_t;

    localparam logic [3:0]  STALL_INIT = 4'(RESET_STALL);
    localparam logic [15:0] WD_LAST    = 16'(LSU_TIMEOUT - 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [2:0] CSR_MRET  = 3'b000;
    localparam logic [2:0] CSR_CSRW  = 3'b001;
    localparam logic [2:0] CSR_ECALL = 3'b011;

    state_t      state, state_nx;
    logic [3:0]  stall_cnt;
    logic [15:0] wd_cnt;
    logic [6:0]  op_q;
    logic [2:0]  csr_q;

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_SYSTEM, OP_FENCE: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    endfunction

    logic is_system, is_ecall, is_mem, no_rf;
    assign is_system = (op_q == OP_SYSTEM);
    assign is_ecall  = is_system && (csr_q == CSR_ECALL);
    assign is_mem    = (op_q == OP_LOAD) || (op_q == OP_STORE);
    // Instructions with no destination register: stores, branches, fences, mret/ecall.
    assign no_rf     = (op_q == OP_STORE) || (op_q == OP_BRANCH) || (op_q == OP_FENCE) ||
                       (is_system && ((csr_q == CSR_MRET) || (csr_q == CSR_ECALL)));

    always_comb begin
        state_nx = state;
        case (state)
            RST_WAIT: if (stall_cnt == 4'd0) state_nx = FETCH;
            FETCH:    if (i_ifu_done) state_nx = DECODE;
            DECODE: begin
                if (i_idu_done) begin
                    if (i_halt_req)          state_nx = HALT;
                    else if (!op_legal(i_op)) state_nx = TRAP;
                    else                     state_nx = EXEC;
                end
            end
            EXEC:     if (i_exu_done) state_nx = is_mem ? MEM : WB;
            MEM: begin
                // A done arriving on the timeout cycle takes precedence.
                if (i_lsu_done)             state_nx = i_lsu_err ? TRAP : WB;
                else if (wd_cnt == WD_LAST) state_nx = TRAP;
            end
            WB:       state_nx = is_ecall ? TRAP : FETCH;
            TRAP:     state_nx = FETCH;
            HALT:     state_nx = HALT;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= RST_WAIT;
            stall_cnt <= STALL_INIT;
            wd_cnt    <= '0;
            op_q      <= '0;
            csr_q     <= '0;
            o_ifu_req <= 1'b0;
            o_idu_req <= 1'b0;
            o_exu_req <= 1'b0;
            o_lsu_req <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == RST_WAIT && stall_cnt != 4'd0) stall_cnt <= stall_cnt - 4'd1;
            wd_cnt <= (state == MEM && state_nx == MEM) ? wd_cnt + 16'd1 : 16'd0;
            if (state == DECODE && i_idu_done) begin
                op_q  <= i_op;
                csr_q <= i_csr_t;
            end
            // Request pulses fire only on the entry cycle of each stage state.
            o_ifu_req <= (state_nx == FETCH)  && (state != FETCH);
            o_idu_req <= (state_nx == DECODE) && (state != DECODE);
            o_exu_req <= (state_nx == EXEC)   && (state != EXEC);
            o_lsu_req <= (state_nx == MEM)    && (state != MEM);
        end
    end

    assign o_pc_we  = (state == WB) || (state == TRAP);
    assign o_rf_we  = (state == WB) && !no_rf;
    assign o_csr_we = (state == WB) && is_system && (csr_q == CSR_CSRW);
    assign o_trap   = (state == TRAP);
    assign o_halted = (state == HALT);
    assign o_state  = state;

`ifdef YSYX_STAGE_CTRL_PERF_EN
    logic [31:0] perf_cycle, perf_instret;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            perf_cycle   <= '0;
            perf_instret <= '0;
        end else begin
            if (state != RST_WAIT && state != HALT) perf_cycle <= perf_cycle + 32'd1;
            if (state == WB) perf_instret <= perf_instret + 32'd1;
        end
    end

    assign o_perf_cycle   = perf_cycle;
    assign o_perf_instret = perf_instret;
`else
    assign o_perf_cycle   = '0;
    assign o_perf_instret = '0;
`endif

endmodule

// File: tb/tb_ysyx_24110006_stage_ctrl.sv
// Scoreboard bench for ysyx_24110006_stage_ctrl: a stage responder answers requests
// with programmable delays, a monitor pops expected WB/TRAP/HALT events and MEM lengths.
module tb_ysyx_24110006_stage_ctrl;

    localparam int RESET_STALL = 2;
    localparam int LSU_TIMEOUT = 16;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic        i_clock = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_ifu_done = 1'b0, i_idu_done = 1'b0, i_exu_done = 1'b0, i_lsu_done = 1'b0;
    logic        i_lsu_err = 1'b0, i_halt_req = 1'b0;
    logic [6:0]  i_op = OP_IMM;
    logic [2:0]  i_csr_t = 3'b000;
    logic        o_ifu_req, o_idu_req, o_exu_req, o_lsu_req;
    logic        o_pc_we, o_rf_we, o_csr_we, o_trap, o_halted;
    logic [2:0]  o_state;
    logic [31:0] o_perf_cycle, o_perf_instret;

    ysyx_24110006_stage_ctrl #(
        .RESET_STALL(RESET_STALL),
        .LSU_TIMEOUT(LSU_TIMEOUT)
    ) dut (
        .i_clock        (i_clock),
        .i_reset_n      (i_reset_n),
        .o_ifu_req      (o_ifu_req),
        .i_ifu_done     (i_ifu_done),
        .o_idu_req      (o_idu_req),
        .i_idu_done     (i_idu_done),
        .i_op           (i_op),
        .i_csr_t        (i_csr_t),
        .i_halt_req     (i_halt_req),
        .o_exu_req      (o_exu_req),
        .i_exu_done     (i_exu_done),
        .o_lsu_req      (o_lsu_req),
        .i_lsu_done     (i_lsu_done),
        .i_lsu_err      (i_lsu_err),
        .o_pc_we        (o_pc_we),
        .o_rf_we        (o_rf_we),
        .o_csr_we       (o_csr_we),
        .o_trap         (o_trap),
        .o_halted       (o_halted),
        .o_state        (o_state),
        .o_perf_cycle   (o_perf_cycle),
        .o_perf_instret (o_perf_instret)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) begin
        cyc <= cyc + 1;
        if (cyc > 20000) begin
            $display("FAIL sim_timeout: cycle %0d exceeded budget 20000", cyc);
            $fatal(1, "simulation budget exhausted");
        end
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Expected events: {state, pc_we, rf_we, csr_we, trap, halted}
    logic [7:0] ev_q[$];
    int         mem_q[$];

    task automatic ev_wb(input logic rf, input logic csr);
        ev_q.push_back({3'd5, 1'b1, rf, csr, 1'b0, 1'b0});
    endtask
    task automatic ev_trap();
        ev_q.push_back({3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    endtask
    task automatic ev_halt();
        ev_q.push_back({3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    endtask

    // Stage responder: done fires dly[k] cycles after request k (0 = entry cycle, -1 = never).
    int   dly[4] = '{0, 1, 0, 0};
    int   cnt[4] = '{-1, -1, -1, -1};
    logic stray = 1'b0;

    initial begin : responder
        logic [3:0] req, dn;
        forever begin
            @(negedge i_clock);
            req = {o_lsu_req, o_exu_req, o_idu_req, o_ifu_req};
            dn  = '0;
            for (int k = 0; k < 4; k++) begin
                if (!i_reset_n) cnt[k] = -1;
                else if (req[k]) cnt[k] = 0;
                else if (cnt[k] >= 0) cnt[k] = cnt[k] + 1;
                if (cnt[k] >= 0 && cnt[k] == dly[k]) begin
                    dn[k]  = 1'b1;
                    cnt[k] = -1;
                end
            end
            {i_lsu_done, i_exu_done, i_idu_done, i_ifu_done} = dn | {4{stray}};
        end
    end

    initial begin : monitor
        logic [2:0] prev;
        int         mlen;
        prev = 3'd0;
        mlen = 0;
        forever begin
            @(negedge i_clock);
            if (!i_reset_n) begin
                prev = 3'd0;
                mlen = 0;
            end else begin
                if (o_state == 3'd4) mlen++;
                else if (prev == 3'd4) begin
                    if (mem_q.size() == 0) chk("mem_extra", 0, 1);
                    else chk("mem_len", mlen, mem_q.pop_front());
                    mlen = 0;
                end
                if (o_state == 3'd5 || o_state == 3'd6 || (o_state == 3'd7 && prev != 3'd7)) begin
                    if (ev_q.size() == 0) chk("ev_extra", 0, 1);
                    else chk("event", {o_state, o_pc_we, o_rf_we, o_csr_we, o_trap, o_halted},
                             ev_q.pop_front());
                end
                if (o_state != 3'd5 && o_state != 3'd6)
                    chk("we_idle", {o_pc_we, o_rf_we, o_csr_we, o_trap}, 0);
                chk("halted_flag", o_halted, (o_state == 3'd7));
                prev = o_state;
            end
        end
    end

    int last_ifu = 0;

    task automatic wait_ifu(output int c);
        int n;
        n = 0;
        c = -1;
        do begin
            @(negedge i_clock);
            n++;
        end while (!o_ifu_req && n < 200);
        if (o_ifu_req) c = cyc;
        else chk("ifu_wait", 0, 1);
    endtask

    // Called on the negedge where o_ifu_req is seen; runs one instruction to the next fetch.
    task automatic run(input string tag, input logic [6:0] op, input logic [2:0] csr,
                       input int dl, input logic err, input int lat);
        int c;
        i_op      = op;
        i_csr_t   = csr;
        dly[3]    = dl;
        i_lsu_err = err;
        wait_ifu(c);
        chk({tag, "_lat"}, c - last_ifu, lat);
        last_ifu = c;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_state"}, o_state, 0);
        chk({tag, "_outs"}, {o_ifu_req, o_idu_req, o_exu_req, o_lsu_req,
                            o_pc_we, o_rf_we, o_csr_we, o_trap, o_halted}, 0);
        chk({tag, "_perf"}, {o_perf_cycle | o_perf_instret}, 0);
    endtask

    initial begin : main
        int c, n;
        logic seen;
        repeat (3) @(negedge i_clock);
        chk_quiet("rst0");
        i_reset_n = 1'b1;
        last_ifu = cyc;
        wait_ifu(c);
        chk("first_fetch", c - last_ifu, RESET_STALL + 1);
        last_ifu = c;

        ev_wb(1, 0);                                   run("alu",      OP_IMM,    3'b000,  0, 0, 5);
        mem_q.push_back(8);  ev_wb(1, 0);              run("load",     OP_LOAD,   3'b000,  7, 0, 13);
        mem_q.push_back(8);  ev_wb(0, 0);              run("store",    OP_STORE,  3'b000,  7, 0, 13);
        mem_q.push_back(16); ev_trap();                run("lsu_tmo",  OP_LOAD,   3'b000, -1, 0, 21);
        mem_q.push_back(16); ev_wb(1, 0);              run("lsu_last", OP_LOAD,   3'b000, 15, 0, 21);
        mem_q.push_back(3);  ev_trap();                run("lsu_err",  OP_LOAD,   3'b000,  2, 1, 8);
        ev_wb(1, 1);                                   run("csrw",     OP_SYSTEM, 3'b001,  0, 0, 5);
        ev_wb(0, 0); ev_trap();                        run("ecall",    OP_SYSTEM, 3'b011,  0, 0, 6);
        ev_wb(0, 0);                                   run("mret",     OP_SYSTEM, 3'b000,  0, 0, 5);
        ev_wb(0, 0);                                   run("branch",   OP_BRANCH, 3'b000,  0, 0, 5);
        ev_wb(1, 0);                                   run("lui",      OP_LUI,    3'b000,  0, 0, 5);
        ev_wb(0, 0);                                   run("fence",    OP_FENCE,  3'b000,  0, 0, 5);
        ev_wb(1, 0);                                   run("jalr",     OP_JALR,   3'b000,  0, 0, 5);
        ev_trap();                                     run("illegal",  OP_BAD,    3'b000,  0, 0, 4);
        ev_trap();                                     run("zero_op",  7'b0000000, 3'b000, 0, 0, 4);

        // Reset asserted mid-access: everything must drop before the next edge.
        i_op   = OP_LOAD;
        dly[3] = -1;
        n = 0;
        do begin
            @(negedge i_clock);
            n++;
        end while (!o_lsu_req && n < 50);
        chk("mem_reach", o_state, 4);
        repeat (3) @(negedge i_clock);
        i_reset_n = 1'b0;
        #1;
        chk_quiet("rst_mem");
        dly[3] = 0;
        repeat (2) @(negedge i_clock);
        i_reset_n = 1'b1;
        last_ifu = cyc;
        wait_ifu(c);
        chk("refetch", c - last_ifu, RESET_STALL + 1);
        last_ifu = c;
        ev_wb(1, 0);                                   run("alu2",     OP_IMM,    3'b000,  0, 0, 5);
`ifdef YSYX_STAGE_CTRL_PERF_EN
        chk("perf_cycle", o_perf_cycle, 5);
        chk("perf_instret", o_perf_instret, 1);
`else
        chk("perf_off", o_perf_cycle | o_perf_instret, 0);
`endif

        // Halt is absorbing; stray done pulses afterwards must not restart anything.
        i_halt_req = 1'b1;
        ev_halt();
        n = 0;
        do begin
            @(negedge i_clock);
            n++;
        end while (!o_halted && n < 50);
        chk("halt_reach", o_state, 7);
        seen = 1'b0;
        stray = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) stray = 1'b0;
            @(negedge i_clock);
            seen = seen | o_ifu_req | o_idu_req | o_exu_req | o_lsu_req;
        end
        chk("halt_state", o_state, 7);
        chk("halt_reqs", seen, 0);
        chk("halt_flag", o_halted, 1);

        chk("ev_left", ev_q.size(), 0);
        chk("mem_left", mem_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
